// File: rtl/fadd_rr_sched_if.sv
// Request, response and adder-side signals shared by the FP16 adder scheduler.
// Latency: n/a (wiring only).
// Backpressure: req_ready is a one-hot grant; nothing else can stall.
interface fadd_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int BITS    = 16
);
    localparam int CNTW = $clog2(NUM_REQ + 1);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*BITS-1:0] req_a;
    logic [NUM_REQ*BITS-1:0] req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [BITS-1:0]         rsp_sum;
    logic                    add_vld;
    logic [BITS-1:0]         add_a;
    logic [BITS-1:0]         add_b;
    logic [BITS-1:0]         add_sum;
    logic [CNTW-1:0]         inflight;

    // Requesters plus the adder result: the environment around the scheduler.
    modport master (
        output req_valid, req_a, req_b, add_sum,
        input  req_ready, rsp_valid, rsp_sum, add_vld, add_a, add_b, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, add_sum,
        output req_ready, rsp_valid, rsp_sum, add_vld, add_a, add_b, inflight
    );
endinterface

// File: rtl/fadd_rr_sched.sv
// Round-robin sharing of one FP16 adder among NUM_REQ requesters, sums routed back by tag.
// Latency: accept to rsp_valid pulse is ADD_LAT+2 cycles, results in issue order.
// Backpressure: one grant per cycle; a requester with an op outstanding waits (ready=0).
module fadd_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int BITS    = 16,
    parameter int ADD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    fadd_rr_sched_if.slave bus
);
    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNTW = $clog2(NUM_REQ + 1);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [NUM_REQ-1:0] busy;
    logic [IDW-1:0]     ptr;
    tag_t               tag_q [ADD_LAT+1];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] retire;
    logic [NUM_REQ-1:0] busy_nxt;
    logic               accept;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     ptr_nxt;
    logic [BITS-1:0]    sel_a;
    logic [BITS-1:0]    sel_b;
    logic [CNTW-1:0]    busy_cnt;
    tag_t               tail;

    assign eligible = bus.req_valid & ~busy & {NUM_REQ{~rst}};
    assign tail     = tag_q[ADD_LAT];

    // Search from ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        logic [IDW:0] idx;
        idx      = '0;
        grant    = '0;
        grant_id = '0;
        accept   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (!accept && eligible[idx[IDW-1:0]]) begin
                accept                = 1'b1;
                grant[idx[IDW-1:0]]   = 1'b1;
                grant_id              = idx[IDW-1:0];
            end
        end
    end

    assign ptr_nxt = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign sel_a   = bus.req_a[grant_id*BITS +: BITS];
    assign sel_b   = bus.req_b[grant_id*BITS +: BITS];

    always_comb begin
        retire = '0;
        if (tail.vld) begin
            retire[tail.id] = 1'b1;
        end
    end

    // Accept and retire can never hit the same requester on one edge.
    assign busy_nxt = (busy & ~retire) | grant;

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy_cnt = busy_cnt + CNTW'(busy_nxt[i]);
        end
    end

    assign bus.req_ready = grant;
    assign bus.add_vld   = tag_q[0].vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= '0;
            ptr           <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_q[k] <= '0;
            end
            bus.add_a     <= '0;
            bus.add_b     <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_sum   <= '0;
            bus.inflight  <= '0;
        end else begin
            busy     <= busy_nxt;
            if (accept) begin
                ptr       <= ptr_nxt;
                bus.add_a <= sel_a;
                bus.add_b <= sel_b;
            end
            tag_q[0] <= {accept, grant_id};
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
            // The tail tag lines up with the adder output for that issue.
            bus.rsp_valid <= retire;
            if (tail.vld) begin
                bus.rsp_sum <= bus.add_sum;
            end
            bus.inflight <= busy_cnt;
        end
    end
endmodule

// File: tb/tb_fadd_rr_sched.sv
// Scoreboard bench for fadd_rr_sched: directed scenarios then randomized traffic,
// with a 2-stage behavioural FP16 adder closing the loop.
module tb_fadd_rr_sched;
    localparam int NR  = 4;
    localparam int W   = 16;
    localparam int LAT = 2;

    typedef struct {
        longint      due;
        int          id;
        logic [15:0] sum;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    bit     started = 1'b0;
    exp_t   q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fadd_rr_sched_if #(.NUM_REQ(NR), .BITS(W)) bus();

    fadd_rr_sched #(.NUM_REQ(NR), .BITS(W), .ADD_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Exact value in units of 2^-24 (smallest FP16 subnormal).
    function automatic longint fp16_fixed(input logic [15:0] x);
        longint mag;
        if (x[14:10] == 5'd0) begin
            mag = longint'(x[9:0]);
        end else begin
            mag = (longint'(x[9:0]) + 1024) << (int'(x[14:10]) - 1);
        end
        return x[15] ? -mag : mag;
    endfunction

    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        longint s, m, mant, rem, half;
        int     p, sh;
        logic   sg;
        if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return 16'h7E00;
        s = fp16_fixed(a) + fp16_fixed(b);
        if (s == 0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
        sg = (s < 0);
        m  = sg ? -s : s;
        if (m < 1024) return {sg, 5'd0, 10'(m)};
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        sh   = p - 10;
        mant = m >> sh;
        rem  = m - (mant << sh);
        if (sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        end
        if (mant == 2048) begin
            mant = 1024;
            sh   = sh + 1;
        end
        if (sh + 1 >= 31) return {sg, 5'h1f, 10'd0};
        return {sg, 5'(sh + 1), 10'(mant)};
    endfunction

    logic [15:0] st1, st2;
    always @(posedge clk) begin
        st1 <= fp16_add(bus.add_a, bus.add_b);
        st2 <= st1;
    end
    assign bus.add_sum = st2;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a requester is busy until its response cycle; grants
    // go to the first waiting requester after the last one served.
    longint      until_c [NR];
    int          mptr = 0;
    bit          prev_g = 1'b0;
    bit          after_rst = 1'b1;
    logic [15:0] prev_a, prev_b;

    always @(negedge clk) begin
        int          g, nbusy, idx;
        logic [NR-1:0] exp_rdy;
        logic [15:0] a, b;
        if (started) begin
            if (rst) begin
                check("ready_in_rst", bus.req_ready, 0);
                for (int i = 0; i < NR; i++) until_c[i] = 0;
                mptr      = 0;
                prev_g    = 1'b0;
                after_rst = 1'b1;
                while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
            end else begin
                if (after_rst) begin
                    check("rst_add_a", bus.add_a, 0);
                    check("rst_add_b", bus.add_b, 0);
                    check("rst_rsp_sum", bus.rsp_sum, 0);
                    after_rst = 1'b0;
                end
                nbusy = 0;
                for (int i = 0; i < NR; i++) if (cyc < until_c[i]) nbusy++;
                check("inflight", bus.inflight, nbusy);
                check("add_vld", bus.add_vld, prev_g);
                if (prev_g) begin
                    check("add_a", bus.add_a, prev_a);
                    check("add_b", bus.add_b, prev_b);
                end
                g = -1;
                for (int k = 0; k < NR; k++) begin
                    idx = (mptr + k) % NR;
                    if (g < 0 && bus.req_valid[idx] && cyc >= until_c[idx]) g = idx;
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                check("req_ready", bus.req_ready, exp_rdy);
                if (g >= 0) begin
                    a = bus.req_a[g*W +: W];
                    b = bus.req_b[g*W +: W];
                    q.push_back('{cyc + LAT + 2, g, fp16_add(a, b)});
                    until_c[g] = cyc + LAT + 2;
                    mptr       = (g + 1) % NR;
                    prev_g     = 1'b1;
                    prev_a     = a;
                    prev_b     = b;
                end else begin
                    prev_g = 1'b0;
                end
            end
        end
    end

    // Monitor: responses must appear exactly when due, and nowhere else.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("rsp_valid", bus.rsp_valid, longint'(1) << e.id);
                check("rsp_sum", bus.rsp_sum, e.sum);
            end else begin
                check("rsp_idle", bus.rsp_valid, 0);
            end
        end
    end

    logic [NR-1:0] acc;

    task automatic tick();
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~acc;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*W +: W]    = a;
        bus.req_b[i*W +: W]    = b;
    endtask

    task automatic do_reset(input int n);
        rst           = 1'b1;
        bus.req_valid = '0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rnd16();
        return 16'($urandom);
    endfunction

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        do_reset(2);
        started = 1'b1;

        // Single op: 1.0 + 1.0
        set_req(0, 16'h3C00, 16'h3C00);
        repeat (8) tick();

        // All four at once from a fresh pointer
        do_reset(1);
        for (int i = 0; i < NR; i++) set_req(i, rnd16(), rnd16());
        repeat (10) tick();

        // One requester streaming back-to-back: 2.0 + -2.0
        do_reset(1);
        for (int n = 0; n < 14; n++) begin
            if (!bus.req_valid[2]) set_req(2, 16'h4000, 16'hC000);
            tick();
        end
        for (int t = 0; t < 8 && bus.req_valid != 0; t++) tick();
        repeat (6) tick();

        // Pointer past requester 1: 3 must win over 0
        do_reset(1);
        set_req(1, rnd16(), rnd16());
        tick();
        set_req(0, rnd16(), rnd16());
        set_req(3, rnd16(), rnd16());
        repeat (8) tick();

        // Reset with three ops in flight
        do_reset(1);
        for (int i = 0; i < NR; i++) set_req(i, rnd16(), rnd16());
        repeat (3) tick();
        do_reset(1);
        repeat (8) tick();

        // Random traffic with occasional resets
        repeat (600) begin
            for (int i = 0; i < NR; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, rnd16(), rnd16());
            end
            if ($urandom_range(0, 199) == 0) do_reset(1);
            else tick();
        end

        for (int t = 0; t < 40 && (bus.req_valid != 0 || q.size() != 0); t++) tick();
        if (bus.req_valid != 0 || q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout pending_valid=%0h expected_left=%0d", bus.req_valid, q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
